// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
//   Shared definitions for the round-robin handshake arbiter:
//   - clog2_min1(): id-width helper that never returns 0, so N=2 still gets a 1-bit id.
//   - ST_* encodings and the stage_state_t enum for the 2-entry output stage.
package hs_arb_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    STG_EMPTY = ST_EMPTY,
    STG_ONE   = ST_ONE,
    STG_TWO   = ST_TWO
  } stage_state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_logic.sv
// rr_grant_logic
//   Combinational rotating-priority grant. Searches req from ptr upward with
//   wrap-around; when lock_en is set, only lock_id may be granted.
// Ports:
//   req      in   N    request vector (upstream valids)
//   ptr      in   IDW  highest-priority index
//   lock_en  in   1    restrict the grant to lock_id
//   lock_id  in   IDW  master holding the packet lock
//   grant    out  N    one-hot grant, zero when nothing may be granted
//   grant_id out  IDW  index of the granted master
module rr_grant_logic
  import hs_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           lock_en,
  input  logic [IDW-1:0] lock_id,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  int             idx;
  logic [IDW-1:0] sel;
  logic           any;

  // Rotating search: walk from ptr+N-1 down to ptr so the last hit is the
  // closest-to-ptr requester; a held lock overrides the search result.
  always_comb begin
    idx = 0;
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
      sel = req[idx] ? IDW'(idx) : sel;
      any = any | req[idx];
    end
    if (lock_en) begin
      grant_id = lock_id;
      grant    = req[lock_id] ? (ONE_HOT0 << lock_id) : '0;
    end else begin
      grant_id = sel;
      grant    = any ? (ONE_HOT0 << sel) : '0;
    end
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter
//   N-to-1 round-robin arbiter feeding one downstream valid/ready channel
//   through a registered 2-entry (main + skid) output stage. Upstream ready
//   depends only on registers and m_valid, never on s_ready.
//   Optional macro ARB_PKT_LOCK_EN: adds m_last/s_last and locks the grant to
//   a master until it completes a beat with m_last=1.
// Ports:
//   clk      in   1        clock, rising edge
//   rst      in   1        asynchronous active-high reset
//   m_valid  in   N        per-master valid
//   m_ready  out  N        per-master ready (one-hot or zero)
//   m_data   in   N*WIDTH  master i at [i*WIDTH +: WIDTH]
//   m_last   in   N        packet end flag (ARB_PKT_LOCK_EN only)
//   s_valid  out  1        downstream valid
//   s_ready  in   1        downstream ready
//   s_data   out  WIDTH    downstream data
//   s_id     out  IDW      source master of s_data
//   s_last   out  1        forwarded m_last (ARB_PKT_LOCK_EN only)
module rr_handshake_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       m_valid,
  output logic [N-1:0]       m_ready,
  input  logic [N*WIDTH-1:0] m_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic [N-1:0]       m_last,
  output logic               s_last,
`endif
  output logic               s_valid,
  input  logic               s_ready,
  output logic [WIDTH-1:0]   s_data,
  output logic [IDW-1:0]     s_id
);

  logic [N-1:0]     grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   ptr;
  logic             lock_en;
  logic [IDW-1:0]   lock_id;
  logic             accept_ok;  // registered inverse of skid_full, also 0 in reset
  logic             hs;
  logic [WIDTH-1:0] hs_data;
  stage_state_t     state;
  logic [WIDTH-1:0] skid_data;
  logic [IDW-1:0]   skid_id;

  rr_grant_logic #(.N(N)) u_grant (
    .req      (m_valid),
    .ptr      (ptr),
    .lock_en  (lock_en),
    .lock_id  (lock_id),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign m_ready = grant & {N{accept_ok}};
  assign hs      = |(m_valid & m_ready);
  assign hs_data = m_data[int'(grant_id)*WIDTH +: WIDTH];

`ifdef ARB_PKT_LOCK_EN
  logic           hs_last;
  logic           skid_last;
  logic           lock_active;
  logic [IDW-1:0] lock_owner;

  assign hs_last = m_last[grant_id];
  assign lock_en = lock_active;
  assign lock_id = lock_owner;

  // Pointer and packet lock: a non-last beat pins the grant; the last beat frees it and advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (hs && hs_last) begin
      ptr         <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
      lock_active <= 1'b0;
    end else if (hs) begin
      lock_active <= 1'b1;
      lock_owner  <= grant_id;
    end else begin
      ptr <= ptr;
    end
  end
`else
  assign lock_en = 1'b0;
  assign lock_id = '0;

  // Pointer: move just past the master that completed a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
    end else begin
      ptr <= ptr;
    end
  end
`endif

  // Output stage FSM: main entry drives s_* directly, skid absorbs one beat under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STG_EMPTY;
      accept_ok <= 1'b0;
      s_valid   <= 1'b0;
      s_data    <= '0;
      s_id      <= '0;
      skid_data <= '0;
      skid_id   <= '0;
`ifdef ARB_PKT_LOCK_EN
      s_last    <= 1'b0;
      skid_last <= 1'b0;
`endif
    end else begin
      case (state)
        STG_EMPTY: begin
          accept_ok <= 1'b1;
          if (hs) begin
            s_data  <= hs_data;
            s_id    <= grant_id;
            s_valid <= 1'b1;
            state   <= STG_ONE;
`ifdef ARB_PKT_LOCK_EN
            s_last  <= hs_last;
`endif
          end
        end
        STG_ONE: begin
          if (s_ready && hs) begin
            s_data <= hs_data;
            s_id   <= grant_id;
`ifdef ARB_PKT_LOCK_EN
            s_last <= hs_last;
`endif
          end else if (s_ready) begin
            s_valid <= 1'b0;
            state   <= STG_EMPTY;
          end else if (hs) begin
            skid_data <= hs_data;
            skid_id   <= grant_id;
            accept_ok <= 1'b0;
            state     <= STG_TWO;
`ifdef ARB_PKT_LOCK_EN
            skid_last <= hs_last;
`endif
          end
        end
        STG_TWO: begin
          if (s_ready) begin
            s_data    <= skid_data;
            s_id      <= skid_id;
            accept_ok <= 1'b1;
            state     <= STG_ONE;
`ifdef ARB_PKT_LOCK_EN
            s_last    <= skid_last;
`endif
          end
        end
        default: begin
          state     <= STG_EMPTY;
          s_valid   <= 1'b0;
          accept_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule
